// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC register and decode.
// Reads pc_in, requests the word from instruction memory, latches it into
// the instruction register and drives the PC register (pc_wr / pc_next).
// Optional build macro: FETCH_TIMEOUT_EN adds a wait-cycle watchdog that
// raises a sticky fetch_err and restarts the request from IDLE.
//
// Handshakes:
//   memory side : imem_req is raised with imem_addr and held, with the address
//                 stable, until the cycle in which imem_ack=1 (data valid in
//                 that same cycle). A reset may abandon a request.
//   decode side : ir_valid/ir_ready, a transfer happens on a rising edge where
//                 both are 1; ir_data/ir_pc stay stable while ir_valid=1 and
//                 ir_ready=0. ir_valid is forced low in a redirect cycle.
module fetch_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_wr,
  output logic [WIDTH-1:0] pc_next,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             ir_valid,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] ir_pc,
  input  logic             ir_ready,
  output logic             fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] drain_addr;
  logic             ir_valid_q;
  logic             timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          waiting;

  assign waiting = ((state == REQ) || (state == DRAIN)) && !imem_ack;
  // The cycle that would bring the count to TIMEOUT_CYCLES is the timeout cycle.
  assign timeout = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count consecutive unanswered wait cycles; the error flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Remember the address of the outstanding request so DRAIN can keep
  // presenting it after a redirect has already moved the PC.
  always_ff @(posedge clk) begin
    if (rst)                drain_addr <= '0;
    else if (state == REQ)  drain_addr <= pc_in;
  end

  // Instruction register: capture on an accepted ack, clear on handshake/redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_valid_q <= 1'b0;
      ir_data    <= '0;
      ir_pc      <= '0;
    end else if (redirect_valid) begin
      ir_valid_q <= 1'b0;
    end else if ((state == REQ) && imem_ack) begin
      ir_valid_q <= 1'b1;
      ir_data    <= imem_rdata;
      ir_pc      <= pc_in;
    end else if ((state == FULL) && ir_valid_q && ir_ready) begin
      ir_valid_q <= 1'b0;
    end
  end

  assign ir_valid = ir_valid_q & ~redirect_valid;

  // Next-state decode plus memory request and PC-write outputs.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    pc_wr      = 1'b0;
    pc_next    = pc_in + WIDTH'(4);
    imem_addr  = (state == DRAIN) ? drain_addr : pc_in;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          state_next = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          pc_wr      = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (redirect_valid)               state_next = REQ;
        else if (ir_valid_q && ir_ready)  state_next = REQ;
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    // A redirect always wins the PC write, including over a same-cycle ack.
    if (redirect_valid) begin
      pc_wr   = 1'b1;
      pc_next = redirect_target;
    end
    if (timeout) state_next = IDLE;
    if (rst) begin
      imem_req = 1'b0;
      pc_wr    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit. The bench plays the PC register and
// the instruction memory; fetched words are queued when the memory returns
// them and compared when decode accepts them.
module tb_fetch_unit;
  localparam int W = 32;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [W-1:0] pc_in = '0;
  logic         pc_wr;
  logic [W-1:0] pc_next;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_target = '0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack = 1'b0;
  logic [W-1:0] imem_rdata = '0;
  logic         ir_valid;
  logic [W-1:0] ir_data;
  logic [W-1:0] ir_pc;
  logic         ir_ready = 1'b0;
  logic         fetch_err;

  fetch_unit #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_wr(pc_wr), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_data(ir_data),
    .ir_pc(ir_pc), .ir_ready(ir_ready), .fetch_err(fetch_err)
  );

  // Scoreboard: {instruction word, pc} in fetch order
  logic [2*W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [W-1:0] pc;
    int           lat;
    logic [W-1:0] data;
    logic [W-1:0] exp_next;
    int           hold;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock: the bench's PC register loads pc_next when pc_wr was high.
  task automatic tick();
    logic         w;
    logic [W-1:0] n;
    w = pc_wr;
    n = pc_next;
    @(posedge clk);
    #1;
    if (w) pc_in = n;
    @(negedge clk);
  endtask

  // Fetch from REQ: lat wait cycles, then an ack carrying data.
  task automatic do_fetch(input logic [W-1:0] pc, input int lat,
                          input logic [W-1:0] data, input logic [W-1:0] exp_next);
    pc_in = pc;
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      #1;
      check("wait_req", W'(imem_req), W'(1));
      check("wait_addr", imem_addr, pc);
      check("wait_pc_wr", W'(pc_wr), W'(0));
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    check("ack_addr", imem_addr, pc);
    check("ack_pc_wr", W'(pc_wr), W'(1));
    check("ack_pc_next", pc_next, exp_next);
    exp_q.push_back({data, pc});
    tick();
    imem_ack = 1'b0;
    #1;
    check("ir_valid_set", W'(ir_valid), W'(1));
  endtask

  // Decode stalls for n cycles with the instruction held.
  task automatic hold_ready(input int n);
    for (int i = 0; i < n; i++) begin
      ir_ready = 1'b0;
      #1;
      check("hold_valid", W'(ir_valid), W'(1));
      check("hold_req", W'(imem_req), W'(0));
      check("hold_pc_wr", W'(pc_wr), W'(0));
      tick();
    end
  endtask

  // Decode accepts; compare against the oldest queued fetch.
  task automatic handshake_pop();
    logic [2*W-1:0] e;
    ir_ready = 1'b1;
    #1;
    check("hs_valid", W'(ir_valid), W'(1));
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL sb_pop: queue empty, got ir_data %h", ir_data);
    end else begin
      e = exp_q.pop_front();
      check("ir_data", ir_data, e[2*W-1:W]);
      check("ir_pc", ir_pc, e[W-1:0]);
    end
    tick();
    ir_ready = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Test sequence
  initial begin
    vecs[0] = '{pc: 32'h0000_0000, lat: 2, data: 32'h0050_0093, exp_next: 32'h0000_0004, hold: 5};
    vecs[1] = '{pc: 32'h0000_0004, lat: 0, data: 32'h00a0_0113, exp_next: 32'h0000_0008, hold: 0};
    vecs[2] = '{pc: 32'h0000_1000, lat: 4, data: 32'hdead_beef, exp_next: 32'h0000_1004, hold: 1};
    vecs[3] = '{pc: 32'hFFFF_FFFC, lat: 1, data: 32'h1234_5678, exp_next: 32'h0000_0000, hold: 2};
    vecs[4] = '{pc: 32'h7FFF_FFFC, lat: 3, data: 32'hcafe_f00d, exp_next: 32'h8000_0000, hold: 0};

    // Reset
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    #1;
    check("rst_ir_valid", W'(ir_valid), W'(0));
    check("rst_ir_data", ir_data, W'(0));
    check("rst_ir_pc", ir_pc, W'(0));
    check("rst_fetch_err", W'(fetch_err), W'(0));
    check("rst_req", W'(imem_req), W'(0));
    check("rst_pc_wr", W'(pc_wr), W'(0));
    rst = 1'b0;
    #1;
    check("idle_req", W'(imem_req), W'(0));
    tick();

    // Table-driven fetches
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i].pc, vecs[i].lat, vecs[i].data, vecs[i].exp_next);
      hold_ready(vecs[i].hold);
      handshake_pop();
      #1;
      check("refetch_req", W'(imem_req), W'(1));
      check("refetch_addr", imem_addr, vecs[i].exp_next);
    end

    // Random fetches
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] rpc;
      rpc = W'($urandom_range(0, 16'hffff)) << 2;
      do_fetch(rpc, $urandom_range(0, 3), W'($urandom), rpc + 32'd4);
      hold_ready($urandom_range(0, 2));
      handshake_pop();
    end

    // Redirect while FULL, with decode trying to accept in the same cycle
    do_fetch(32'h40, 0, 32'h0000_0013, 32'h44);
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    ir_ready        = 1'b1;
    #1;
    check("full_rd_pc_wr", W'(pc_wr), W'(1));
    check("full_rd_pc_next", pc_next, 32'h100);
    check("full_rd_ir_valid", W'(ir_valid), W'(0));
    exp_q.delete();
    tick();
    redirect_valid = 1'b0;
    ir_ready       = 1'b0;
    #1;
    check("full_rd_req", W'(imem_req), W'(1));
    check("full_rd_addr", imem_addr, 32'h100);
    check("full_rd_flushed", W'(ir_valid), W'(0));

    // Redirect while REQ with the ack still pending: DRAIN then refetch
    imem_ack = 1'b0;
    #1;
    check("req_wait", W'(imem_req), W'(1));
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    #1;
    check("req_rd_pc_wr", W'(pc_wr), W'(1));
    check("req_rd_pc_next", pc_next, 32'h200);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("drain_req", W'(imem_req), W'(1));
    check("drain_addr", imem_addr, 32'h100);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hbad0_bad0;
    #1;
    check("drain_ack_addr", imem_addr, 32'h100);
    check("drain_ack_pc_wr", W'(pc_wr), W'(0));
    tick();
    imem_ack = 1'b0;
    #1;
    check("drain_discard", W'(ir_valid), W'(0));
    check("drain_next_req", W'(imem_req), W'(1));
    check("drain_next_addr", imem_addr, 32'h200);

    // Redirect and ack in the same cycle
    pc_in           = 32'h8;
    imem_ack        = 1'b1;
    imem_rdata      = 32'h0000_0073;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    #1;
    check("rdack_pc_wr", W'(pc_wr), W'(1));
    check("rdack_pc_next", pc_next, 32'h300);
    tick();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rdack_ir_valid", W'(ir_valid), W'(0));
    check("rdack_addr", imem_addr, 32'h300);

    // Reset in the middle of a request
    rst = 1'b1;
    #1;
    check("midrst_req", W'(imem_req), W'(0));
    check("midrst_pc_wr", W'(pc_wr), W'(0));
    tick();
    rst = 1'b0;
    #1;
    check("midrst_idle_req", W'(imem_req), W'(0));
    check("midrst_ir_valid", W'(ir_valid), W'(0));
    tick();
    #1;
    check("midrst_refetch", W'(imem_req), W'(1));

`ifdef FETCH_TIMEOUT_EN
    // No ack: error after 16 wait cycles, one idle cycle, then re-request
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_wait_req", W'(imem_req), W'(1));
      check("to_err_low", W'(fetch_err), W'(0));
      tick();
    end
    #1;
    check("to_req_drop", W'(imem_req), W'(0));
    check("to_err_set", W'(fetch_err), W'(1));
    tick();
    #1;
    check("to_rereq", W'(imem_req), W'(1));
    check("to_rereq_addr", imem_addr, 32'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("to_err_clear", W'(fetch_err), W'(0));
`else
    check("err_tied_low", W'(fetch_err), W'(0));
`endif

    check("sb_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the PC register. It reads the current PC and issues a request to instruction memory, which may take a variable number of cycles to reply. It latches the returned word into an instruction register for decode and computes the next PC (PC+4 or a redirect target) together with the PC write enable. It is the sole driver of the PC register's write enable and data input.

Parameters:
WIDTH, 32, address/data width
TIMEOUT_CYCLES, 16, wait-cycle limit before fetch_err (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
pc_in  in  WIDTH  current PC, from the PC register output
pc_wr  out  1  PC register write enable
pc_next  out  WIDTH  PC register data input
redirect_valid  in  1  branch/jump taken; flush fetch
redirect_target  in  WIDTH  new PC when redirect_valid=1
imem_req  out  1  memory request, held until imem_ack
imem_addr  out  WIDTH  request address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  WIDTH  instruction word
ir_valid  out  1  instruction register holds a valid instruction
ir_data  out  WIDTH  latched instruction
ir_pc  out  WIDTH  PC of the latched instruction
ir_ready  in  1  decode accepts the instruction
fetch_err  out  1  sticky timeout flag (0 when the macro is absent)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ir_valid=0, ir_data=0, ir_pc=0, fetch_err=0. While rst=1, imem_req=0 and pc_wr=0. rst overrides every other input.
- The FSM has four states: IDLE, REQ, FULL, DRAIN. All outputs listed below are combinational from state and inputs unless stated otherwise.
- IDLE:
  - imem_req=0.
  - Next state is REQ unconditionally.
  - A redirect in this state writes the PC (see redirect rules).
- REQ:
  - imem_req=1 and imem_addr=pc_in. imem_addr stays stable until ack.
  - On imem_ack=1 (no redirect): capture ir_data<=imem_rdata and ir_pc<=pc_in; set ir_valid<=1.
  - In that same cycle, pc_wr=1 and pc_next=pc_in+4 (modulo 2^WIDTH, wrap-around allowed). Next state is FULL.
  - On imem_ack=0: stay in REQ.
- FULL:
  - imem_req=0.
  - Handshake occurs when ir_valid & ir_ready. On handshake: ir_valid<=0 and next state is REQ, which fetches the already-updated pc_in.
  - Without ir_ready: hold the instruction, stay in FULL.
  - Throughput is at most one instruction per 2+memory-latency cycles; there is no prefetch.
- DRAIN:
  - imem_req=1 with the original address held (request protocol: req stays high until ack).
  - On imem_ack: discard the data and go to REQ.
- Redirect (redirect_valid=1), in any state, highest priority after rst:
  - pc_wr=1 and pc_next=redirect_target; this overrides the PC+4 write from a same-cycle ack.
  - ir_valid<=0. The ir_valid output is also gated combinationally by ~redirect_valid, so no handshake can complete during a redirect cycle.
  - From IDLE or FULL: next state is REQ.
  - From REQ with imem_ack=1: data is discarded, next state is REQ.
  - From REQ with imem_ack=0: next state is DRAIN, and imem_addr stays at the old address.
  - From DRAIN with imem_ack=0: stay in DRAIN. With imem_ack=1: go to REQ.
- pc_wr=0 in every case not listed above; pc_next=pc_in+4 when pc_wr=0.
- A reset in the middle of a request drops imem_req immediately. The memory must tolerate an abandoned request.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined:
  - A wait counter of width clog2(TIMEOUT_CYCLES+1) counts consecutive cycles in REQ/DRAIN with imem_ack=0. It clears on ack, on leaving those states, and on rst.
  - When the count reaches TIMEOUT_CYCLES, fetch_err<=1 (sticky until rst) and state<=IDLE, with imem_req=0.
  - After IDLE the unit re-requests the same pc_in.
- Undefined: no counter is built, fetch_err is tied to 0, and the unit waits indefinitely.

Test Plan:
- Reset then pc_in=0x0, memory acks after 3 cycles with 0x00500093 -> imem_req high 3 cycles at addr 0x0; ack cycle pc_wr=1, pc_next=0x4; next cycle ir_valid=1, ir_data=0x00500093, ir_pc=0x0.
- ir_ready held 0 for 5 cycles after ir_valid -> ir_valid/ir_data stable, imem_req=0, pc_wr=0 throughout; ir_ready=1 -> next cycle imem_req=1, addr=0x4.
- In FULL, redirect_valid=1 with target 0x100 -> pc_wr=1, pc_next=0x100, ir_valid output 0 in that cycle; next fetch addr=0x100.
- Redirect to 0x200 while in REQ with ack pending 2 more cycles -> DRAIN holds old addr, ack data discarded (ir_valid stays 0), then request at 0x200.
- Redirect and imem_ack in the same cycle at pc 0x8 -> pc_next=0x300 (not 0xC), ir_valid stays 0; pc_in=0xFFFFFFFC ack -> pc_next=0x0.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> fetch_err=1 after 16 wait cycles, imem_req drops for one cycle then re-asserts; rst clears fetch_err.
